mmu_mem_arbiter: RTL and testbench
==================================

Name: mmu_mem_arbiter

Overview:
Shares the single-page MMU translator and the one memory bus between the instruction-fetch port and the data port. Per access it selects one requester, drives that requester's virtual address to the MMU and captures the physical address and fault flag in the grant cycle. It then runs the bus transaction with a timeout and returns a registered acknowledge, read data and error to the owner. It also generates the pipeline stall.

Parameters:
STARVE_LIMIT, 4, consecutive data grants while if_req waits before ifetch is forced through (1..15)
TIMEOUT, 64, BUSY cycles without mem_ack before abort; 0 disables timeout (0..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch request; held with if_vaddr until if_ack
if_vaddr  input  32  fetch virtual address
if_ack  output  1  one-cycle completion pulse, fetch port
if_rdata  output  32  fetched word, valid with if_ack
if_err  output  1  MMU fault or bus timeout, valid with if_ack
d_req  input  1  data request; held with d_we, d_vaddr, d_wdata until d_ack
d_we  input  1  1 = store, 0 = load
d_vaddr  input  32  data virtual address
d_wdata  input  32  store data
d_ack  output  1  one-cycle completion pulse, data port
d_rdata  output  32  load data, valid with d_ack (0 for stores)
d_err  output  1  MMU fault or bus timeout, valid with d_ack
mmu_vaddr_o  output  32  virtual address to MMU
mmu_paddr_i  input  32  translated address from MMU
mmu_error_i  input  1  MMU page-mismatch fault
mem_req  output  1  bus request, held until mem_ack or abort
mem_we  output  1  bus write enable
mem_addr  output  32  bus physical address
mem_wdata  output  32  bus write data
mem_rdata  input  32  bus read data, valid with mem_ack
mem_ack  input  1  bus completion
stall  output  1  pipeline stall

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- Reset values: every registered output is 0, state = IDLE, starve and timeout counters = 0. Reset mid-transaction aborts it: mem_req drops immediately and no ack is issued.
- States and transitions:
  - IDLE: grant when either request is high.
  - GRANT: not a separate state; the grant occurs in the IDLE cycle.
  - FAULT: set when mmu_error_i=1 in the grant cycle. FAULT -> RESP with err=1, no bus cycle.
  - BUSY: set when there is no fault. mem_req=1 from the next cycle.
  - RESP: owner ack=1 for exactly one cycle, then -> IDLE. No grant is made in RESP, so a request dropped after ack is never served twice.
- Grant cycle:
  - mmu_vaddr_o = selected vaddr, combinational.
  - Latch owner, mmu_paddr_i, we (forced 0 for fetch) and wdata.
  - Outside IDLE, mmu_vaddr_o = latched vaddr. A later MMU reconfiguration does not affect an in-flight access.
  - mmu_vaddr_o = if_vaddr in IDLE with no request.
- BUSY:
  - mem_addr, mem_we and mem_wdata are stable, driven from the latches.
  - On mem_ack=1: capture mem_rdata (or 0 for a store), drop mem_req next cycle, -> RESP with err=0.
  - Timeout counter increments each BUSY cycle without mem_ack. On reaching TIMEOUT: drop mem_req, -> RESP with err=1, rdata=0.
  - If mem_ack arrives in the same cycle the timeout is reached, mem_ack wins.
- mem_ack outside BUSY is ignored.
- Latency:
  - Grant at cycle T, mem_req visible at T+1, mem_ack earliest at T+1, ack at T+2.
  - Fault: ack+err at T+2, same latency as the normal path; FAULT is one cycle.
- Priority:
  - Data port wins when both request.
  - Starve counter increments on each data grant while if_req=1. When it equals STARVE_LIMIT, the next grant goes to ifetch.
  - The counter clears on any ifetch grant, or in IDLE when if_req=0.
- stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
- Non-owner ack and err stay 0. rdata holds its last value except when ack is asserted.

Test Plan:
- Single fetch: if_vaddr=0x00001004, MMU maps it to 0x00042004, mem_ack two cycles after mem_req with rdata 0xDEADBEEF → mem_addr=0x00042004, mem_we=0, if_ack pulses once with if_rdata=0xDEADBEEF, if_err=0; stall is high until the ack cycle.
- Store: d_we=1, d_vaddr=0x00001010, d_wdata=0x12345678, mem_ack one cycle after mem_req → mem_we=1, mem_wdata=0x12345678, d_ack with d_rdata=0, d_err=0; if_ack stays 0.
- MMU fault: d_vaddr=0x00002000, mmu_error_i=1 → mem_req never rises; d_ack=1 and d_err=1 two cycles after grant.
- Contention and starvation: if_req and d_req held high continuously, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I; each ack is exactly one cycle.
- Timeout: TIMEOUT=8, mem_ack never asserted → mem_req high for 8 cycles then low, ack with err=1, rdata=0. Repeat with mem_ack on the 8th BUSY cycle → err=0 and data returned.
- Async reset: assert rst_n=0 mid-BUSY between clock edges → mem_req and all acks go to 0 immediately. A late mem_ack after release is ignored; the next request completes normally.

Source files
------------

// File: rtl/mmu_mem_arbiter.sv
// Arbitrates fetch/data ports onto one MMU and memory bus; the grant cycle translates, BUSY runs the bus, and ack follows two cycles after grant at the earliest.
// Requesters hold their request until ack; bus stalls are covered by a timeout, and stall stays high for every request not being acknowledged this cycle.
module mmu_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_vaddr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_vaddr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mmu_vaddr_o,
  input  logic [31:0] mmu_paddr_i,
  input  logic        mmu_error_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, FAULT, BUSY, RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        owner_d;
  logic [31:0] vaddr_q;
  logic [3:0]  starve_cnt;
  logic [7:0]  tmo_cnt;

  logic        sel_d;
  logic        grant;
  logic        tmo_hit;
  logic        resp_set;
  logic        resp_err;
  logic [31:0] resp_dat;

  // Data wins unless ifetch has been passed over STARVE_LIMIT times in a row.
  assign sel_d   = d_req & ~(if_req & (starve_cnt == STARVE_MAX));
  assign grant   = (state == IDLE) & (if_req | d_req);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  assign mmu_vaddr_o = (state != IDLE) ? vaddr_q : (sel_d ? d_vaddr : if_vaddr);
  assign stall       = (if_req & ~if_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    resp_set  = 1'b0;
    resp_err  = 1'b0;
    resp_dat  = '0;
    case (state)
      IDLE: begin
        if (if_req | d_req) state_nxt = mmu_error_i ? FAULT : BUSY;
      end
      FAULT: begin
        state_nxt = RESP;
        resp_set  = 1'b1;
        resp_err  = 1'b1;
      end
      BUSY: begin
        // A bus ack in the timeout cycle still counts as success.
        if (mem_ack) begin
          state_nxt = RESP;
          resp_set  = 1'b1;
          resp_dat  = mem_we ? '0 : mem_rdata;
        end else if (tmo_hit) begin
          state_nxt = RESP;
          resp_set  = 1'b1;
          resp_err  = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_d    <= 1'b0;
      vaddr_q    <= '0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      if_ack <= 1'b0;
      if_err <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;

      if (grant) begin
        owner_d   <= sel_d;
        vaddr_q   <= mmu_vaddr_o;
        mem_addr  <= mmu_paddr_i;
        mem_we    <= sel_d & d_we;
        mem_wdata <= sel_d ? d_wdata : '0;
        mem_req   <= ~mmu_error_i;
        tmo_cnt   <= '0;
      end

      if (state == BUSY) begin
        if (resp_set) mem_req <= 1'b0;
        else          tmo_cnt <= tmo_cnt + 8'd1;
      end

      if (resp_set) begin
        if (owner_d) begin
          d_ack   <= 1'b1;
          d_err   <= resp_err;
          d_rdata <= resp_dat;
        end else begin
          if_ack   <= 1'b1;
          if_err   <= resp_err;
          if_rdata <= resp_dat;
        end
      end

      if (grant) begin
        if (!sel_d)     starve_cnt <= '0;
        else if (if_req) starve_cnt <= starve_cnt + 4'd1;
      end else if ((state == IDLE) && !if_req) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mmu_mem_arbiter.sv
// Directed bench for mmu_mem_arbiter with a page-mapping MMU model and a programmable-latency bus responder.
module tb_mmu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_vaddr, d_vaddr, d_wdata;
  logic        if_ack, if_err, d_ack, d_err;
  logic [31:0] if_rdata, d_rdata;
  logic [31:0] mmu_vaddr_o, mmu_paddr_i;
  logic        mmu_error_i;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall;

  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_at   = 0;
  int          busy_cyc = 0;
  int          req_cnt  = 0;
  logic        late_ack = 1'b0;
  int          n;

  always #5 clk = ~clk;

  // Page 0x00001 maps to 0x00042; page 0x00002 is unmapped.
  assign mmu_paddr_i = {20'h00042, mmu_vaddr_o[11:0]};
  assign mmu_error_i = (mmu_vaddr_o[31:12] == 20'h00002);

  mmu_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_vaddr(if_vaddr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_vaddr(d_vaddr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mmu_vaddr_o(mmu_vaddr_o), .mmu_paddr_i(mmu_paddr_i), .mmu_error_i(mmu_error_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall)
  );

  // Bus responder: acks in the ack_at-th cycle that mem_req is high (0 = never).
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) busy_cyc = busy_cyc + 1;
      else         busy_cyc = 0;
      mem_ack = late_ack | (mem_req && (ack_at != 0) && (busy_cyc == ack_at));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Counts negedges until an ack is seen, bounded at 40.
  task automatic wait_ack(output int cyc);
    cyc     = 0;
    req_cnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_req) req_cnt++;
    end while (!(if_ack | d_ack) && cyc < 40);
  endtask

  initial begin
    logic [9:0] order;
    order    = 10'b1111011110;
    rst_n    = 1'b0;
    if_req   = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    if_vaddr = '0;
    d_vaddr  = '0;
    d_wdata  = '0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst mem_req", mem_req, 0);
    check("rst if_ack", if_ack, 0);
    check("rst d_ack", d_ack, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst if_rdata", if_rdata, 0);
    check("rst d_rdata", d_rdata, 0);
    check("rst stall", stall, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch, bus acks in its second cycle.
    ack_at    = 2;
    mem_rdata = 32'hDEADBEEF;
    if_vaddr  = 32'h00001004;
    if_req    = 1'b1;
    #1;
    check("fetch mmu_vaddr", mmu_vaddr_o, 32'h00001004);
    check("fetch stall grant", stall, 1);
    wait_ack(n);
    check("fetch latency", n, 3);
    check("fetch req cycles", req_cnt, 2);
    check("fetch if_ack", if_ack, 1);
    check("fetch if_rdata", if_rdata, 32'hDEADBEEF);
    check("fetch if_err", if_err, 0);
    check("fetch d_ack", d_ack, 0);
    check("fetch mem_addr", mem_addr, 32'h00042004);
    check("fetch mem_we", mem_we, 0);
    check("fetch stall ack", stall, 0);
    if_req = 1'b0;
    @(negedge clk);
    check("fetch ack pulse", if_ack, 0);

    // Contention: both held, expected grant order D,D,D,D,I,D,D,D,D,I.
    ack_at    = 1;
    mem_rdata = 32'h5A5A1234;
    if_vaddr  = 32'h00001100;
    d_vaddr   = 32'h00001200;
    if_req    = 1'b1;
    d_req     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_ack(n);
      check($sformatf("cont%0d latency", i), n, 2);
      check($sformatf("cont%0d owner", i), d_ack, order[9-i]);
      check($sformatf("cont%0d single", i), if_ack & d_ack, 0);
      if (i == 9) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      @(negedge clk);
      check($sformatf("cont%0d ack pulse", i), if_ack | d_ack, 0);
    end
    check("cont d_rdata", d_rdata, 32'h5A5A1234);
    check("cont if_rdata", if_rdata, 32'h5A5A1234);

    // Store, bus acks in its first cycle.
    d_we    = 1'b1;
    d_vaddr = 32'h00001010;
    d_wdata = 32'h12345678;
    d_req   = 1'b1;
    @(negedge clk);
    check("store mem_req", mem_req, 1);
    check("store mem_we", mem_we, 1);
    check("store mem_wdata", mem_wdata, 32'h12345678);
    check("store mem_addr", mem_addr, 32'h00042010);
    wait_ack(n);
    check("store latency", n, 1);
    check("store d_ack", d_ack, 1);
    check("store d_rdata", d_rdata, 0);
    check("store d_err", d_err, 0);
    check("store if_ack", if_ack, 0);
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    check("store ack pulse", d_ack, 0);

    // MMU fault: no bus cycle, error ack two cycles after grant.
    d_vaddr = 32'h00002000;
    d_req   = 1'b1;
    #1;
    check("fault mmu_vaddr", mmu_vaddr_o, 32'h00002000);
    wait_ack(n);
    check("fault latency", n, 2);
    check("fault mem_req", req_cnt, 0);
    check("fault d_ack", d_ack, 1);
    check("fault d_err", d_err, 1);
    d_req = 1'b0;
    @(negedge clk);

    // Timeout on fetch: 8 cycles of mem_req then error ack with zero data.
    ack_at   = 0;
    if_vaddr = 32'h00001300;
    if_req   = 1'b1;
    wait_ack(n);
    check("tmo latency", n, 9);
    check("tmo req cycles", req_cnt, 8);
    check("tmo if_err", if_err, 1);
    check("tmo if_rdata", if_rdata, 0);
    if_req = 1'b0;
    @(negedge clk);

    // Bus ack in the timeout cycle wins.
    ack_at    = 8;
    mem_rdata = 32'hCAFEF00D;
    if_req    = 1'b1;
    wait_ack(n);
    check("tmo-ack latency", n, 9);
    check("tmo-ack req cycles", req_cnt, 8);
    check("tmo-ack if_err", if_err, 0);
    check("tmo-ack if_rdata", if_rdata, 32'hCAFEF00D);
    if_req = 1'b0;
    @(negedge clk);

    // Async reset in the middle of BUSY.
    ack_at  = 0;
    d_vaddr = 32'h00001400;
    d_req   = 1'b1;
    repeat (3) @(negedge clk);
    check("arst pre mem_req", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst mem_req", mem_req, 0);
    check("arst d_ack", d_ack, 0);
    check("arst if_ack", if_ack, 0);
    d_req = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    check("late ack d_ack", d_ack, 0);
    check("late ack if_ack", if_ack, 0);
    check("late ack mem_req", mem_req, 0);

    ack_at    = 1;
    mem_rdata = 32'h0BADCAFE;
    if_vaddr  = 32'h00001008;
    if_req    = 1'b1;
    wait_ack(n);
    check("post-rst latency", n, 2);
    check("post-rst if_ack", if_ack, 1);
    check("post-rst if_rdata", if_rdata, 32'h0BADCAFE);
    check("post-rst if_err", if_err, 0);
    if_req = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
